// File: rtl/mips_cpu_alu_pkg.sv
// Shared encodings for the ALU HI/LO unit and its sequencer: mult_op codes and controller states.
// No logic of its own; helper functions classify ops.
package mips_cpu_alu_pkg;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] MULTU = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] DIVU  = 3'b100;
    localparam logic [2:0] MTHI  = 3'b101;
    localparam logic [2:0] MFLO  = 3'b110;
    localparam logic [2:0] MFHI  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MULT) || (op == MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO sequencer: launches mult/div one cycle after accept, done after MULT_LAT/DIV_LAT cycles.
// Backpressure: req_ready is low whenever an operation is in flight; decode holds the request.
module mips_cpu_muldiv_ctrl
    import mips_cpu_alu_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        stall,
    output logic [2:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_write,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_load;
    logic [2:0]       lat_op;
    logic [31:0]      lat_a, lat_b;
    logic             accept_md;

    assign cnt_load = is_div(lat_op) ? DIV_LOAD : MULT_LOAD;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        unit_op    = NOP;
        unit_a     = lat_a;
        unit_b     = lat_b;
        unit_write = 1'b0;
        done       = 1'b0;
        accept_md  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                unit_a    = req_a;
                unit_b    = req_b;
                if (req_valid) begin
                    case (req_op)
                        MFHI, MFLO: unit_op = req_op;
                        MTHI: begin
                            unit_op    = MTHI;
                            unit_write = 1'b1;
                        end
                        MULT, MULTU, DIV, DIVU: begin
                            accept_md = 1'b1;
                            state_nxt = LAUNCH;
                        end
                        default: ;
                    endcase
                end
            end
            LAUNCH: begin
                unit_op    = lat_op;
                unit_write = 1'b1;
                cnt_nxt    = cnt_load;
                if (cnt_load == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                unit_op = lat_op;
                cnt_nxt = cnt - CNT_W'(1);
                // Guarding with <= keeps a corrupted count from wedging the FSM.
                if (cnt <= CNT_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = req_valid & ~req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_op   <= NOP;
            lat_a    <= '0;
            lat_b    <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept_md) begin
                lat_op <= req_op;
                lat_a  <= req_a;
                lat_b  <= req_b;
                // Captured from req_b at accept so the flag is already visible in the LAUNCH cycle.
                div_zero <= is_div(req_op) && (req_b == 32'd0);
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Bench for mips_cpu_muldiv_ctrl: directed requests push expected writes/done/reads into queues,
// a monitor pops and compares them as the DUT presents them; a small HI/LO model follows unit writes.
module tb_mips_cpu_muldiv_ctrl;
    import mips_cpu_alu_pkg::*;

    localparam int ML = 4;
    localparam int DL = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        req_ready, stall, unit_write, busy, done, div_zero;
    logic [2:0]  unit_op;
    logic [31:0] unit_a, unit_b;

    mips_cpu_muldiv_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .stall(stall),
        .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b), .unit_write(unit_write),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [2:0] op; logic [31:0] a; logic [31:0] b; logic bsy; } wr_t;
    typedef struct { int cyc; logic dz; } done_t;
    typedef struct { int cyc; logic [2:0] op; logic [31:0] data; } rd_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    rd_t   rd_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference HI/LO unit, driven only by the controller's unit_* outputs.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    always @(posedge clk) begin
        if (!reset && unit_write) begin
            case (unit_op)
                MULT:  {m_hi, m_lo} <= smul(unit_a, unit_b);
                MULTU: {m_hi, m_lo} <= {32'd0, unit_a} * {32'd0, unit_b};
                DIV: if (unit_b != 32'd0) begin
                    m_lo <= $signed(unit_a) / $signed(unit_b);
                    m_hi <= $signed(unit_a) % $signed(unit_b);
                end
                DIVU: if (unit_b != 32'd0) begin
                    m_lo <= unit_a / unit_b;
                    m_hi <= unit_a % unit_b;
                end
                MTHI:  m_hi <= unit_a;
                default: ;
            endcase
        end
    end

    wr_t   mw;
    done_t md;
    rd_t   mr;

    initial forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (unit_write) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got write op %0d at cycle %0d, expected no write", unit_op, cyc);
                end else begin
                    mw = wr_q.pop_front();
                    chk("write_cycle", cyc, mw.cyc);
                    chk("write_op", 32'(unit_op), 32'(mw.op));
                    chk("write_a", unit_a, mw.a);
                    chk("write_b", unit_b, mw.b);
                    chk("write_busy", 32'(busy), 32'(mw.bsy));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", cyc, md.cyc);
                    chk("done_div_zero", 32'(div_zero), 32'(md.dz));
                    chk("done_busy", 32'(busy), 32'd1);
                end
            end
            if (req_valid && req_ready && (req_op == MFHI || req_op == MFLO)) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_read: got read op %0d at cycle %0d, expected none", req_op, cyc);
                end else begin
                    mr = rd_q.pop_front();
                    chk("read_cycle", cyc, mr.cyc);
                    chk("read_op", 32'(unit_op), 32'(mr.op));
                    chk("read_data", (req_op == MFHI) ? m_hi : m_lo, mr.data);
                end
            end
        end
    end

    // Present a request at the current cycle and expect acceptance after wait_exp stall cycles.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int wait_exp, input logic [31:0] rd_exp, input logic dz_exp);
        int  acc, n;
        bit  ok;
        acc = cyc + wait_exp;
        if (is_mult(op) || is_div(op)) begin
            wr_q.push_back('{acc + 1, op, a, b, 1'b1});
            done_q.push_back('{acc + (is_div(op) ? DL : ML), dz_exp});
        end else if (op == MTHI) begin
            wr_q.push_back('{acc, op, a, b, 1'b0});
        end else if (op == MFHI || op == MFLO) begin
            rd_q.push_back('{acc, op, rd_exp});
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            if (stall) n++;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: op %0d not accepted in 100 cycles, expected %0d", op, wait_exp);
        end
        chk("stall_cycles", n, wait_exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = NOP;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = NOP; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_unit_write", 32'(unit_write), 32'd0);
        idle_cycles(1);

        // DIV 9/0 aborted by reset while waiting.
        wr_q.push_back('{cyc + 1, DIV, 32'd9, 32'd0, 1'b1});
        req_valid = 1'b1; req_op = DIV; req_a = 32'd9; req_b = 32'd0;
        idle_cycles(1);
        req_valid = 1'b0; req_op = NOP;
        chk("launch_div_zero", 32'(div_zero), 32'd1);
        idle_cycles(3);
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_div_zero", 32'(div_zero), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        issue(MULT, 32'd2, 32'd3, 0, 32'd0, 1'b0);

        issue(MULT, 32'd7, 32'd6, 4, 32'd0, 1'b0);
        issue(MFLO, 32'd0, 32'd0, 4, 32'd42, 1'b0);

        issue(DIVU, 32'd100, 32'd7, 0, 32'd0, 1'b0);
        idle_cycles(33);
        issue(MFHI, 32'd0, 32'd0, 0, 32'd2, 1'b0);
        issue(MFLO, 32'd0, 32'd0, 0, 32'd14, 1'b0);

        issue(DIV, 32'd5, 32'd0, 0, 32'd0, 1'b1);
        chk("div0_flag", 32'(div_zero), 32'd1);
        issue(MULTU, 32'd3, 32'd5, 33, 32'd0, 1'b0);
        chk("multu_clears_div_zero", 32'(div_zero), 32'd0);
        issue(MFLO, 32'd0, 32'd0, 4, 32'd15, 1'b0);

        issue(MULT, 32'hFFFF_FFFD, 32'd4, 0, 32'd0, 1'b0);
        issue(MFHI, 32'd0, 32'd0, 4, 32'hFFFF_FFFF, 1'b0);
        issue(MFLO, 32'd0, 32'd0, 0, 32'hFFFF_FFF4, 1'b0);

        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 0, 32'd0, 1'b0);
        issue(DIVU, 32'd1000, 32'd10, 4, 32'd0, 1'b0);
        issue(MFHI, 32'd0, 32'd0, 33, 32'd0, 1'b0);
        issue(MFLO, 32'd0, 32'd0, 0, 32'd100, 1'b0);

        issue(NOP, 32'd1, 32'd2, 0, 32'd0, 1'b0);
        issue(MTHI, 32'hDEAD_BEEF, 32'd0, 0, 32'd0, 1'b0);
        issue(MFHI, 32'd0, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        issue(MFLO, 32'd0, 32'd0, 0, 32'd100, 1'b0);

        idle_cycles(5);
        chk("wr_q_empty", wr_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
Name: mips_cpu_muldiv_ctrl

Overview:
Sequencer and hazard controller for the HI/LO multiply/divide unit inside the ALU. It accepts multiply/divide and HI/LO-move requests from decode, launches multi-cycle operations into the unit, and counts each operation's latency. It stalls the pipeline while HI/LO are not yet valid, and flags divide-by-zero. It sits between decode/execute control and the ALU's mult_op/write/a/b inputs.

Parameters:
MULT_LAT, 4, cycles from launch until HI/LO hold the MULT/MULTU result (>=1)
DIV_LAT, 33, cycles from launch until HI/LO hold the DIV/DIVU result (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  decode presents a HI/LO-class op
req_op  in  3  op code (package encoding)
req_a  in  32  rs operand
req_b  in  32  rt operand
req_ready  out  1  request accepted this cycle (req_valid & req_ready)
stall  out  1  pipeline must hold the requesting instruction (= req_valid & ~req_ready)
unit_op  out  3  mult_op to the ALU mult/div unit
unit_a  out  32  a operand to the unit
unit_b  out  32  b operand to the unit
unit_write  out  1  write strobe to the unit
busy  out  1  multi-cycle operation in flight
done  out  1  one-cycle pulse when HI/LO become valid
div_zero  out  1  last launched DIV/DIVU had b == 0

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- On reset: state IDLE, counter 0, latched op NOP, latched operands 0, busy 0, done 0, div_zero 0, unit_write 0. Reset mid-operation aborts the operation; the controller is IDLE on the next cycle and accepts a request immediately.
- States are IDLE, LAUNCH and WAIT.
- IDLE:
  - req_ready=1 for every op.
  - If req_op is MFHI or MFLO: unit_op=req_op and unit_a/unit_b=req_a/req_b, both combinational. unit_write=0, so the ALU returns HI/LO in the same cycle.
  - If req_op is MTHI: unit_op=MTHI, unit_write=1 in the same cycle, a=req_a. The op completes in one cycle with no state change.
  - If req_op is MULT, MULTU, DIV or DIVU (accept cycle T): latch op, req_a and req_b; go to LAUNCH. unit_op=NOP during T.
  - If req_valid=0 or req_op=NOP: unit_op=NOP and unit_write=0.
- LAUNCH (cycle T+1):
  - unit_op=latched op, unit_a/unit_b=latched operands, unit_write=1 for exactly this cycle.
  - Load counter with LAT-1, where LAT is MULT_LAT or DIV_LAT.
  - busy=1.
  - If LAT=1: done=1 this cycle and next state is IDLE.
  - Otherwise next state is WAIT.
- WAIT:
  - unit_op and operands stay at the latched values; unit_write=0; busy=1.
  - The counter decrements each cycle. When it reaches 1, done=1 and next state is IDLE.
  - done is therefore high in cycle T+LAT, and busy is high in cycles T+1 through T+LAT.
- While busy=1:
  - req_ready=0 for all ops, so a new mult/div or MFHI/MFLO/MTHI stalls.
  - No request is lost: a stalled request is held by decode and accepted in the first IDLE cycle, T+LAT+1.
- Back-to-back mult/div: the second request is accepted at T+LAT+1. No overlap.
- div_zero:
  - Registered at LAUNCH: set if the op is DIV/DIVU and the latched b==0; cleared if the op is MULT/MULTU.
  - Otherwise it holds its value.
  - The operation still runs for the full DIV_LAT. HI/LO content after a divide by zero is whatever the unit produces.
- Counter width is $clog2(DIV_LAT+1). Throughout, busy equals (state != IDLE).

Decomposition:
- Package mips_cpu_alu_pkg holds the 3-bit mult_op localparams: NOP=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MFLO=110, MFHI=111. It also holds the state enum (IDLE, LAUNCH, WAIT).
- The ALU and this controller both import the package.
- No sub-module is needed. The latency counter is inline.

Test Plan:
- Reset: assert reset for 2 cycles during a DIV in WAIT -> next cycle busy=0, done=0, div_zero=0, req_ready=1. A MULT presented immediately is accepted.
- MULT a=7, b=6 at T, then MFLO requested from T+1 -> unit_write=1 only at T+1. stall=1 for T+1..T+4 and done=1 at T+4. MFLO accepted at T+5 with result 42.
- DIVU a=100, b=7 -> done at T+33. Then MFHI returns 2 and MFLO returns 14 with zero stall cycles.
- DIV a=5, b=0 -> div_zero=1 from T+1, busy for the full 33 cycles. A following MULTU clears div_zero at its LAUNCH.
- Back-to-back: MULT then DIVU held valid -> DIVU accepted exactly at T+5 and done at T+5+33. No unit_write pulse between the two LAUNCH cycles.
- Idle MTHI a=0xDEADBEEF -> unit_write=1 in the same cycle, no busy. The next-cycle MFHI returns 0xDEADBEEF.
